expr_string_gen: RTL and testbench

//   Transmit side of the expression-string channel. On start, emits one pseudo-random but

---
 rtl/expr_string_gen.sv | 155 +++++++++++++++
 tb/tb_expr_string_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/expr_string_gen.sv
// rtl/expr_string_gen.sv - random legal expression source ('0'-'9', '+', '*', parens), one char per beat
// Optional ERR_INJECT_EN: adds err_pos input; the char at that index is replaced by '?'.
module expr_string_gen #(
    parameter int LEN_MAX   = 32,
    parameter int DEPTH_MAX = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
    input  logic [15:0]                  seed,
`ifdef ERR_INJECT_EN
    input  logic [$clog2(LEN_MAX+1)-1:0] err_pos,
`endif
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = $clog2(LEN_MAX+1);
    localparam int DW = $clog2(DEPTH_MAX+2);

    localparam logic [7:0] CH_LP   = 8'h28;
    localparam logic [7:0] CH_RP   = 8'h29;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_ADD  = 8'h2B;
    localparam logic [7:0] CH_ZERO = 8'h30;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [7:0]      char_q, char_d;

    logic [15:0]     seed_eff, lfsr_adv;
    logic [7:0]      pick_bits;
    logic [DW-1:0]   pick_depth, new_depth;
    logic [31:0]     pick_r;
    logic            pick_operand, pick_end, op_ok, cur_term;
    logic [7:0]      new_char;
    logic [3:0]      dig_v, dig;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign seed_eff = (seed == 16'h0000) ? 16'hACE1 : seed;
    assign lfsr_adv = lfsr_step(lfsr_q);
    assign cur_term = (char_q != CH_LP) && (char_q != CH_ADD) && (char_q != CH_MUL);

    // The chooser sees post-beat values while running, or the fresh seed at start accept.
    always_comb begin
        if (state_q == RUN) begin
            pick_bits    = lfsr_adv[7:0];
            pick_depth   = depth_q;
            pick_r       = 32'(LEN_MAX) - 32'(cnt_q) - 32'd1;
            pick_operand = !cur_term;
        end else begin
            pick_bits    = seed_eff[7:0];
            pick_depth   = '0;
            pick_r       = 32'(LEN_MAX);
            pick_operand = 1'b1;
        end
    end

    always_comb begin
        new_char  = 8'h00;
        new_depth = pick_depth;
        pick_end  = 1'b0;
        op_ok     = pick_r >= (32'(pick_depth) + 32'd3);
        dig_v     = pick_bits[7:4];
        dig       = (dig_v >= 4'd10) ? (dig_v - 4'd10) : dig_v;
        if (pick_operand) begin
            if (pick_bits[1:0] == 2'b11 && 32'(pick_depth) < 32'(DEPTH_MAX) && op_ok) begin
                new_char  = CH_LP;
                new_depth = pick_depth + DW'(1);
            end else begin
                new_char = CH_ZERO + {4'h0, dig};
            end
        end else if (pick_bits[2:0] < 3'd3 && op_ok) begin
            new_char = pick_bits[3] ? CH_MUL : CH_ADD;
        end else if (pick_depth != '0) begin
            new_char  = CH_RP;
            new_depth = pick_depth - DW'(1);
        end else begin
            pick_end = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = seed_eff;
                    cnt_d   = '0;
                    depth_d = new_depth;
                    char_d  = new_char;
                end
            end
            RUN: begin
                if (out_ready) begin
                    lfsr_d = lfsr_adv;
                    cnt_d  = cnt_q + CW'(1);
                    if (pick_end) begin
                        state_d = FIN;
                    end else begin
                        char_d  = new_char;
                        depth_d = new_depth;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            lfsr_q  <= 16'hACE1;
            cnt_q   <= '0;
            depth_q <= '0;
            char_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            char_q  <= char_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign out_last  = (state_q == RUN) && pick_end;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

`ifdef ERR_INJECT_EN
    // Only the visible char is corrupted; grammar tracking uses char_q untouched.
    assign out_data = (state_q != RUN) ? 8'h00 : ((cnt_q == err_pos) ? 8'h3F : char_q);
`else
    assign out_data = (state_q == RUN) ? char_q : 8'h00;
`endif

endmodule

// File: tb/tb_expr_string_gen.sv
// tb/tb_expr_string_gen.sv - directed checks plus grammar checker over random seeds
module tb_expr_string_gen;

    logic        clk = 1'b0;
    logic        clr;
    logic        start, start1;
    logic [15:0] seed, seed1;
    logic        out_ready, ready1;
    logic [7:0]  out_data, data1;
    logic        out_valid, out_last, busy, done;
    logic        valid1, last1, busy1, done1;
`ifdef ERR_INJECT_EN
    logic [5:0]  err_pos;
    logic        err_pos1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    expr_string_gen #(.LEN_MAX(32), .DEPTH_MAX(4)) u_dut (
        .clk(clk), .clr(clr), .start(start), .seed(seed),
`ifdef ERR_INJECT_EN
        .err_pos(err_pos),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    expr_string_gen #(.LEN_MAX(1), .DEPTH_MAX(4)) u_len1 (
        .clk(clk), .clr(clr), .start(start1), .seed(seed1),
`ifdef ERR_INJECT_EN
        .err_pos(err_pos1),
`endif
        .out_data(data1), .out_valid(valid1), .out_ready(ready1),
        .out_last(last1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_char(input string tag, input logic [7:0] ch, input logic last);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, ch});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    endtask

    task automatic run_random(input logic [15:0] s);
        int   len = 0, depth = 0, maxd = 0;
        bit   opnd = 1, legal = 1, ended = 0, held = 0, hold_ok = 1;
        logic [7:0] hold_d = 8'h00;
        logic       hold_l = 1'b0;
        logic [7:0] ch;
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            if (held && (out_data !== hold_d || out_last !== hold_l || out_valid !== 1'b1))
                hold_ok = 0;
            out_ready = 1'($urandom_range(0, 1));
            held   = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (out_valid && out_ready) begin
                ch = out_data;
                len++;
                if (opnd) begin
                    if (ch == "(") depth++;
                    else if (ch >= "0" && ch <= "9") opnd = 0;
                    else legal = 0;
                end else begin
                    if (ch == "+" || ch == "*") opnd = 1;
                    else if (ch == ")") begin
                        if (depth == 0) legal = 0;
                        else depth--;
                    end else legal = 0;
                end
                if (depth > maxd) maxd = depth;
                if (out_last) ended = 1;
            end
            @(negedge clk);
        end
        chk("rnd_ended", {31'd0, ended}, 32'd1);
        chk("rnd_legal", {31'd0, legal}, 32'd1);
        chk("rnd_ends_operand", {31'd0, opnd}, 32'd0);
        chk("rnd_final_depth", depth, 32'd0);
        chk("rnd_len_ok", {31'd0, len <= 32}, 32'd1);
        chk("rnd_depth_ok", {31'd0, maxd <= 4}, 32'd1);
        chk("rnd_hold", {31'd0, hold_ok}, 32'd1);
        chk("rnd_done", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; seed = 16'h0; out_ready = 1'b1;
        start1 = 1'b0; seed1 = 16'h0; ready1 = 1'b1;
`ifdef ERR_INJECT_EN
        err_pos = 6'h3F; err_pos1 = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // seed 0 maps to ACE1: single char '4' then end
        start = 1'b1; seed = 16'h0000;
        @(negedge clk); start = 1'b0;
        chk_char("s0_c0", "4", 1'b1);
        chk("s0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("s0_fin_valid", {31'd0, out_valid}, 32'd0);
        chk("s0_fin_done", {31'd0, done}, 32'd1);
        chk("s0_fin_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; seed = 16'h0003;
        @(negedge clk); start = 1'b0;
        chk("fin_start_ignored_busy", {31'd0, busy}, 32'd0);
        chk("fin_start_ignored_done", {31'd0, done}, 32'd0);
        chk("fin_start_ignored_valid", {31'd0, out_valid}, 32'd0);

        start = 1'b1; seed = 16'hACE1;
        @(negedge clk); start = 1'b0;
        chk_char("sace1_c0", "4", 1'b1);
        @(negedge clk);
        chk("sace1_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // seed 3: "(0)*3+2", stall of 5 cycles, start while busy ignored
        start = 1'b1; seed = 16'h0003;
        @(negedge clk); start = 1'b0;
        chk_char("s3_c0", "(", 1'b0);
        start = 1'b1; seed = 16'h0001;
        @(negedge clk);
        chk_char("s3_c1", "0", 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk_char("s3_c2", ")", 1'b0);
        @(negedge clk);
        chk_char("s3_c3", "*", 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_char("s3_hold", "*", 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_char("s3_c4", "3", 1'b0);
        @(negedge clk);
        chk_char("s3_c5", "+", 1'b0);
        @(negedge clk);
        chk_char("s3_c6", "2", 1'b0);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;

        // seed 1: "0+0*" then clr mid-string, then clean restart
        start = 1'b1; seed = 16'h0001;
        @(negedge clk); start = 1'b0;
        chk_char("s1_c0", "0", 1'b0);
        @(negedge clk);
        chk_char("s1_c1", "+", 1'b0);
        @(negedge clk);
        chk_char("s1_c2", "0", 1'b0);
        @(negedge clk);
        chk_char("s1_c3", "*", 1'b0);
        clr = 1'b1;
        #1;
        chk("clr_data", {24'd0, out_data}, 32'd0);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_last", {31'd0, out_last}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        @(negedge clk); clr = 1'b0;
        start = 1'b1; seed = 16'h0001;
        @(negedge clk); start = 1'b0;
        chk_char("s1r_c0", "0", 1'b0);
        @(negedge clk);
        chk_char("s1r_c1", "+", 1'b0);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;

        // LEN_MAX=1 instance: always one digit
        start1 = 1'b1; seed1 = 16'h00F3;
        @(negedge clk); start1 = 1'b0;
        chk("l1_valid", {31'd0, valid1}, 32'd1);
        chk("l1_data", {24'd0, data1}, {24'd0, 8'h35});
        chk("l1_last", {31'd0, last1}, 32'd1);
        @(negedge clk);
        chk("l1_done", {31'd0, done1}, 32'd1);
        chk("l1_fin_valid", {31'd0, valid1}, 32'd0);
        @(negedge clk);
        chk("l1_idle_done", {31'd0, done1}, 32'd0);
        chk("l1_idle_busy", {31'd0, busy1}, 32'd0);
        start1 = 1'b1; seed1 = 16'h0003;
        @(negedge clk); start1 = 1'b0;
        chk("l1b_data", {24'd0, data1}, {24'd0, 8'h30});
        chk("l1b_last", {31'd0, last1}, 32'd1);
        repeat (2) @(negedge clk);

`ifdef ERR_INJECT_EN
        err_pos = 6'd0;
        start = 1'b1; seed = 16'h0003;
        @(negedge clk); start = 1'b0;
        chk_char("inj_c0", 8'h3F, 1'b0);
        @(negedge clk);
        chk_char("inj_c1", "0", 1'b0);
        @(negedge clk);
        chk_char("inj_c2", ")", 1'b0);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        err_pos = 6'h3F;
`endif

        for (int n = 0; n < 40; n++)
            run_random(16'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
